// File: rtl/alu_io_bridge_pkg.sv
// Shared definitions for the CPU IO port to ALU bridge: register bit
// positions, ALU type and mode codes, and the sequencer state encoding.
package alu_io_bridge_pkg;

  // io_control bit positions
  localparam int IO_CTRL_STA       = 0;
  localparam int IO_CTRL_MODEL_LSB = 1;
  localparam int IO_CTRL_MODEL_MSB = 2;
  localparam int IO_CTRL_ALU_LSB   = 3;
  localparam int IO_CTRL_ALU_MSB   = 6;
  localparam int IO_CTRL_CLR       = 7;

  // io_status bit positions
  localparam int IO_STS_DONE = 0;
  localparam int IO_STS_BUSY = 1;
  localparam int IO_STS_TMO  = 2;
  localparam int IO_STS_BADT = 3;
  localparam int IO_STS_OVR  = 4;

  // One-hot ALU operation codes; every other pattern is rejected
  localparam logic [3:0] ALU_MULTIPLY = 4'b1000;
  localparam logic [3:0] ALU_DIVISION = 4'b0100;
  localparam logic [3:0] ALU_SQRTPOWS = 4'b0010;
  localparam logic [3:0] ALU_UNKNOWN  = 4'b0001;

  // Mode codes passed through to the ALU untouched
  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // True when the requested type is one of the four one-hot codes
  function automatic logic is_legal_type(input logic [3:0] t);
    return (t == ALU_MULTIPLY) || (t == ALU_DIVISION) ||
           (t == ALU_SQRTPOWS) || (t == ALU_UNKNOWN);
  endfunction

endpackage

// File: rtl/alu_io_bridge_watchdog.sv
// Loadable up-counter used to bound how long the bridge waits for the ALU.
// tc is high while the count sits one below TIMEOUT_CYCLES, so the edge
// that sees tc is the TIMEOUT_CYCLES-th RUN edge after the load.
module alu_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Load clears the count; enable advances it by one
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/alu_io_bridge.sv
// Handshake stage between the CPU IO registers and the shared ALU. A start
// edge latches operands and command, holds alu_start until the ALU reports
// done or the watchdog expires, and captures the results. Sticky status
// flags are reported back through io_status.
module alu_io_bridge
  import alu_io_bridge_pkg::*;
#(
  parameter int GENERAL_REG_WIDTH = 16,
  parameter int MAX_SQRT_WIDTH    = 13,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [GENERAL_REG_WIDTH-1:0] io_control,
  input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutA,
  input  logic [GENERAL_REG_WIDTH-1:0] io_dataoutB,
  output logic [GENERAL_REG_WIDTH-1:0] io_status,
  output logic [GENERAL_REG_WIDTH-1:0] io_datainA,
  output logic [GENERAL_REG_WIDTH-1:0] io_datainB,
  output logic [MAX_SQRT_WIDTH-1:0]    alu_x,
  output logic [MAX_SQRT_WIDTH-1:0]    alu_y,
  output logic [3:0]                   alu_type,
  output logic [1:0]                   mode_type,
  output logic                         alu_start,
  input  logic [MAX_SQRT_WIDTH-1:0]    FOUT,
  input  logic [MAX_SQRT_WIDTH-1:0]    POUT,
  input  logic                         alu_is_done
);

  state_e                    state_reg;
  logic                      sta_q_reg;
  logic                      clr_q_reg;
  logic [MAX_SQRT_WIDTH-1:0] x_reg;
  logic [MAX_SQRT_WIDTH-1:0] y_reg;
  logic [MAX_SQRT_WIDTH-1:0] fout_reg;
  logic [MAX_SQRT_WIDTH-1:0] pout_reg;
  logic [3:0]                type_reg;
  logic [1:0]                mode_reg;
  logic                      start_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic                      timeout_reg;
  logic                      bad_type_reg;
  logic                      overrun_reg;

  logic       start_edge;
  logic       clear_edge;
  logic [3:0] req_type;
  logic       type_ok;
  logic       accept;
  logic       wd_load;
  logic       wd_en;
  logic       wd_tc;

  // Edge detection against the previous cycle's control bits
  assign start_edge = io_control[IO_CTRL_STA] & ~sta_q_reg;
  assign clear_edge = io_control[IO_CTRL_CLR] & ~clr_q_reg;
  assign req_type   = io_control[IO_CTRL_ALU_MSB:IO_CTRL_ALU_LSB];
  assign type_ok    = is_legal_type(req_type);
  assign accept     = start_edge & type_ok & (state_reg != ST_RUN);

  // Watchdog restarts on every accepted start and counts RUN cycles only
  assign wd_load = accept;
  assign wd_en   = (state_reg == ST_RUN) & ~alu_is_done;

  alu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .load(wd_load),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  // Sequencer: IDLE -> RUN on a legal start, RUN -> HOLD on done or timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      sta_q_reg    <= 1'b0;
      clr_q_reg    <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      fout_reg     <= '0;
      pout_reg     <= '0;
      type_reg     <= '0;
      mode_reg     <= '0;
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      bad_type_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      sta_q_reg <= io_control[IO_CTRL_STA];
      clr_q_reg <= io_control[IO_CTRL_CLR];

      // Clearing comes first so a start in the same cycle can re-flag errors
      if (clear_edge) begin
        done_reg     <= 1'b0;
        timeout_reg  <= 1'b0;
        bad_type_reg <= 1'b0;
        overrun_reg  <= 1'b0;
      end

      case (state_reg)
        ST_IDLE, ST_HOLD: begin
          if (start_edge && type_ok) begin
            x_reg     <= io_dataoutA[MAX_SQRT_WIDTH-1:0];
            y_reg     <= io_dataoutB[MAX_SQRT_WIDTH-1:0];
            type_reg  <= req_type;
            mode_reg  <= io_control[IO_CTRL_MODEL_MSB:IO_CTRL_MODEL_LSB];
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            state_reg <= ST_RUN;
          end else begin
            if (start_edge) begin
              bad_type_reg <= 1'b1;
            end
            if (clear_edge) begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          if (start_edge) begin
            overrun_reg <= 1'b1;
          end
          if (alu_is_done) begin
            fout_reg  <= FOUT;
            pout_reg  <= POUT;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_HOLD;
          end else if (wd_tc) begin
            start_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b1;
            state_reg   <= ST_HOLD;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          start_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Results are zero-extended bit by bit so equal widths need no special case
  genvar gi;
  generate
    for (gi = 0; gi < GENERAL_REG_WIDTH; gi++) begin : g_ext
      if (gi < MAX_SQRT_WIDTH) begin : g_bit
        assign io_datainA[gi] = fout_reg[gi];
        assign io_datainB[gi] = pout_reg[gi];
      end else begin : g_zero
        assign io_datainA[gi] = 1'b0;
        assign io_datainB[gi] = 1'b0;
      end
    end
    if (GENERAL_REG_WIDTH > MAX_SQRT_WIDTH) begin : g_trunc
      logic unused_operand_bits;
      assign unused_operand_bits = ^{io_dataoutA[GENERAL_REG_WIDTH-1:MAX_SQRT_WIDTH],
                                     io_dataoutB[GENERAL_REG_WIDTH-1:MAX_SQRT_WIDTH]};
    end
    if (GENERAL_REG_WIDTH > IO_CTRL_CLR + 1) begin : g_ctrl_spare
      logic unused_ctrl_bits;
      assign unused_ctrl_bits = ^io_control[GENERAL_REG_WIDTH-1:IO_CTRL_CLR+1];
    end
  endgenerate

  // Assemble the status word from the flag registers
  always_comb begin
    io_status              = '0;
    io_status[IO_STS_DONE] = done_reg;
    io_status[IO_STS_BUSY] = busy_reg;
    io_status[IO_STS_TMO]  = timeout_reg;
    io_status[IO_STS_BADT] = bad_type_reg;
    io_status[IO_STS_OVR]  = overrun_reg;
  end

  assign alu_x     = x_reg;
  assign alu_y     = y_reg;
  assign alu_type  = type_reg;
  assign mode_type = mode_reg;
  assign alu_start = start_reg;

endmodule

// File: doc/alu_io_bridge.md
# alu_io_bridge

Handshake and sequencing stage between the pipelined CPU's IO register port and the shared ALU. It sits downstream of the CPU's io_control, io_dataoutA and io_dataoutB outputs, and upstream of the ALU's X_IN, Y_IN, alu_start, alu_type and mode_type inputs. On a CPU start edge it latches the operands and command, holds the ALU start level, waits for alu_is_done under a watchdog, and captures FOUT and POUT into result registers. It also reports sticky done, busy and error flags back through io_status.

## Interface
Parameters:
- GENERAL_REG_WIDTH, 16, width of CPU IO registers
- MAX_SQRT_WIDTH, 13, ALU operand/result width; must be less than or equal to GENERAL_REG_WIDTH
- TIMEOUT_CYCLES, 1023, maximum number of RUN cycles before the watchdog aborts the operation; must be at least 1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- io_control  in  16  CPU control register: bit0 start, bits2:1 mode, bits6:3 alu_type, bit7 clear
- io_dataoutA  in  16  operand A from CPU
- io_dataoutB  in  16  operand B from CPU
- io_status  out  16  bit0 done, bit1 busy, bit2 timeout, bit3 bad_type, bit4 overrun, bits15:5 always 0
- io_datainA  out  16  captured FOUT, zero-extended
- io_datainB  out  16  captured POUT, zero-extended
- alu_x  out  13  latched io_dataoutA[12:0]
- alu_y  out  13  latched io_dataoutB[12:0]
- alu_type  out  4  latched one-hot type
- mode_type  out  2  latched mode
- alu_start  out  1  level start to the ALU
- FOUT  in  13  ALU primary result
- POUT  in  13  ALU secondary result
- alu_is_done  in  1  ALU completion

## Operation
- Reset value of every output is 0.
- ctrl_q is io_control registered every cycle.
  - start_edge = io_control[0] & ~ctrl_q[0]
  - clear_edge = io_control[7] & ~ctrl_q[7]
- Legal alu_type values: 1000, 0100, 0010, 0001. Any other value is bad.
- State IDLE:
  - start_edge with a legal type: latch alu_x, alu_y, alu_type, mode_type; set alu_start=1; clear done; reset the watchdog to 0; go to RUN.
  - start_edge with a bad type: set bad_type; latch nothing; stay in IDLE.
- State RUN (busy=1):
  - alu_is_done=1: capture FOUT into io_datainA and POUT into io_datainB; set alu_start=0 and done=1; go to HOLD.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES: set alu_start=0 and timeout=1; leave the result registers unchanged; go to HOLD.
  - start_edge in RUN: set overrun; the operation continues unaffected.
- State HOLD: results and done stay stable.
  - start_edge: behaves as in IDLE. A legal start re-arms (done cleared in the same edge).
  - clear_edge alone: go to IDLE.
- Flag clearing:
  - done is cleared by an accepted start or by clear_edge.
  - timeout, bad_type and overrun are sticky and cleared only by clear_edge.
- Simultaneous start_edge and clear_edge:
  - Error flags are cleared, then the start is processed, so a new bad_type or overrun is still recorded.
  - done ends at 0.
- alu_is_done seen in IDLE or HOLD is ignored.
- Widths: operands are truncated to bits 12:0; results are zero-extended to 16 bits.

## Timing
- Edge E samples start_edge. After E: alu_start=1, busy=1, operands valid.
- The ALU raises alu_is_done at edge D. After D: done=1, busy=0, alu_start=0, result registers valid.
  - Bridge overhead: 1 cycle in, 1 cycle out.
- The earliest accepted alu_is_done is the edge after E (a 1-cycle RUN).
- Timeout: alu_start drops exactly TIMEOUT_CYCLES RUN cycles after E.
- rst during RUN: alu_start and busy are 0 after the reset edge, state is IDLE, and a late alu_is_done is ignored.
- A start bit held high starts exactly one operation. It must go low and high again to start another.

## Structure
- Shared package:
  - io_control bit positions (IO_CTRL_STA=0, MODEL 2:1, ALU 6:3, CLR=7)
  - io_status bit positions (DONE=0, BUSY=1, TMO=2, BADT=3, OVR=4)
  - ALU type codes ALU_MULTIPLY, ALU_DIVISION, ALU_SQRTPOWS, ALU_UNKNOWN
  - mode codes
  - state encoding IDLE/RUN/HOLD
- Sub-module alu_watchdog: a loadable up-counter with a terminal-count flag, parameterized by TIMEOUT_CYCLES.

## Test plan
- Multiply: io_dataoutA=240, io_dataoutB=106, io_control=0x0043, ALU model asserts done after 20 cycles with FOUT=0x0ABC, POUT=0x0012 -> alu_start high for exactly 20 cycles; io_datainA=0x0ABC, io_datainB=0x0012; io_status=0x0001.
- Bad type: io_control=0x0061 (type 1100) -> alu_start stays 0; io_status=0x0008; a clear pulse (0x0080) returns io_status to 0x0000.
- Timeout: TIMEOUT_CYCLES=8, the ALU never completes -> alu_start drops 8 cycles after the start edge; io_status=0x0004; results stay 0.
- Overrun plus hold: a second start edge in RUN -> io_status bit4=1; the first result is still captured; start held high for 50 cycles gives exactly one alu_start assertion.
- Reset mid-RUN: rst asserted 5 cycles into RUN, then the ALU raises done -> all outputs 0; done ignored; a new start afterwards completes normally.
